// File: rtl/r_alu_pkg.sv
// Shared types for the round-robin R-type ALU arbiter.
// Provides the op-code enum, the legality check, the slot-state enum and the datapath width.
package r_alu_pkg;

    localparam int XLEN = 32;

    // The op code is {instr[30], funct3}.
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b1000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b1101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic is_legal_op(logic [3:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/r_alu_core.sv
// Purely combinational RV32 R-type ALU.
// Illegal codes produce zero and raise the illegal flag.
module r_alu_core
    import r_alu_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic [XLEN-1:0] out,
    output logic            illegal
);

    logic [4:0] shamt;
    assign shamt = in2[4:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        out     = '0;
        illegal = 1'b0;
        unique case (alu_op_e'(op))
            OP_ADD:  out = in1 + in2;
            OP_SUB:  out = in1 - in2;
            OP_SLL:  out = in1 << shamt;
            OP_SLT:  out = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
            OP_SLTU: out = {{(XLEN-1){1'b0}}, in1 < in2};
            OP_XOR:  out = in1 ^ in2;
            OP_SRL:  out = in1 >> shamt;
            OP_SRA:  out = XLEN'($signed(in1) >>> shamt);
            OP_OR:   out = in1 | in2;
            OP_AND:  out = in1 & in2;
            default: begin
                out     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/r_alu_arbiter.sv
// Round-robin arbiter sharing one R-type ALU among NUM_REQ issue ports.
// Each result is registered into a single response slot, tagged with its requester index.
module r_alu_arbiter
    import r_alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_instr,
    input  logic [NUM_REQ*XLEN-1:0] req_in1,
    input  logic [NUM_REQ*XLEN-1:0] req_in2,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [XLEN-1:0]         rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_err
);

    slot_state_e     state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            rsp_err_q, rsp_err_d;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] cand;
    logic            free;
    logic            accept;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_in1, alu_in2, alu_out;
    logic            alu_illegal;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign free   = (state_q == SLOT_EMPTY) || rsp_ready;
    assign accept = gnt_found && free && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        alu_op  = {req_instr[32*gnt_idx + 30], req_instr[32*gnt_idx + 12 +: 3]};
        alu_in1 = req_in1[XLEN*gnt_idx +: XLEN];
        alu_in2 = req_in2[XLEN*gnt_idx +: XLEN];
    end

    r_alu_core u_core (
        .op      (alu_op),
        .in1     (alu_in1),
        .in2     (alu_in2),
        .out     (alu_out),
        .illegal (alu_illegal)
    );

    // Slot state machine: register, next-state logic, output decode.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= SLOT_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (accept)         state_d = SLOT_FULL;
                else if (rsp_ready) state_d = SLOT_EMPTY;
            end
            default:                state_d = SLOT_EMPTY;
        endcase
    end

    assign rsp_valid = (state_q == SLOT_FULL);

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        if (accept) begin
            rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            rsp_data_d = alu_out;
            rsp_id_d   = gnt_idx;
            rsp_err_d  = alu_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload registers are reset too, because the observable outputs must read zero out of reset.
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_r_alu_arbiter.sv
// Self-checking bench for r_alu_arbiter: directed cases from the test plan plus a randomized run.
// All expected values come from a behavioural model of the slot, the rotation pointer and the ALU.
module tb_r_alu_arbiter;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_instr, req_in1, req_in2;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_id;
    logic          rsp_err;

    logic [31:0] t_instr [N];
    logic [31:0] t_in1   [N];
    logic [31:0] t_in2   [N];

    assign req_instr = {t_instr[1], t_instr[0]};
    assign req_in1   = {t_in1[1], t_in1[0]};
    assign req_in2   = {t_in2[1], t_in2[0]};

    always #5 clk = ~clk;

    r_alu_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_instr (req_instr),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_id;
    bit          m_err;
    logic [N-1:0] acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {err, data} straight from the op-code table.
    function automatic logic [32:0] ref_alu(logic [3:0] code, logic [31:0] a, logic [31:0] b);
        int unsigned sh = b[4:0];
        logic [31:0] r;
        case (code)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << sh;
            4'b0010: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b1101: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic logic [3:0] code_of(logic [31:0] instr);
        return {instr[30], instr[14:12]};
    endfunction

    task automatic set_req(input int i, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w;
        w        = $urandom;
        w[30]    = code[3];
        w[14:12] = code[2:0];
        t_instr[i] = w;
        t_in1[i]   = a;
        t_in2[i]   = b;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0; m_err = 0;
    endtask

    // One clock: called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic rr);
        bit found;
        int g;
        bit free;
        logic [N-1:0] exp_ready;
        logic [32:0] r;
        rsp_ready = rr;
        #2;
        found = 0; g = 0;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (!found && req_valid[idx]) begin found = 1; g = idx; end
        end
        free = !m_valid || rr;
        exp_ready = (found && free) ? N'(1 << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        acc = exp_ready;
        if (found && free) begin
            r       = ref_alu(code_of(t_instr[g]), t_in1[g], t_in2[g]);
            m_data  = r[31:0];
            m_err   = r[32];
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % N;
        end else if (rr) begin
            m_valid = 0;
        end
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_data", rsp_data, m_data);
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_err", 32'(rsp_err), 32'(m_err));
    endtask

    logic [31:0] held_data;
    logic [3:0]  sweep_codes [6] = '{4'b1000, 4'b1101, 4'b0101, 4'b0010, 4'b0011, 4'b0001};
    logic [31:0] sweep_exp   [6] = '{32'h7FFF_FFFC, 32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0, 32'd0};

    initial begin
        model_reset();
        acc       = '0;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        set_req(0, 4'b0000, 32'd1, 32'd2);
        set_req(1, 4'b0000, 32'd3, 32'd4);
        #3;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); @(posedge clk);
        #3;
        req_valid = 2'b00;
        rst_n     = 1'b1;
        @(posedge clk); #1;

        // Single add.
        req_valid = 2'b01;
        set_req(0, 4'b0000, 32'd5, 32'd7);
        step(1'b1);
        check("add_data", rsp_data, 32'd12);

        // Op sweep on req1.
        req_valid = 2'b10;
        for (int i = 0; i < 6; i++) begin
            set_req(1, sweep_codes[i], 32'h8000_0000, 32'h0000_0004);
            step(1'b1);
            check("sweep_data", rsp_data, sweep_exp[i]);
            check("sweep_id", 32'(rsp_id), 32'd1);
        end

        // Contention: ids must alternate starting from req0.
        req_valid = 2'b11;
        set_req(0, 4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F);
        set_req(1, 4'b0110, 32'h1234_0000, 32'h0000_5678);
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            check("contend_id", 32'(rsp_id), 32'(i % 2));
        end

        // Back-pressure: hold a result, then drain with a back-to-back accept.
        req_valid = 2'b00;
        step(1'b1);
        req_valid = 2'b01;
        set_req(0, 4'b1000, 32'd100, 32'd1);
        step(1'b0);
        held_data = rsp_data;
        check("bp_first", held_data, 32'd99);
        req_valid = 2'b11;
        set_req(0, 4'b0000, 32'd10, 32'd20);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            check("bp_hold_data", rsp_data, 32'd99);
        end
        step(1'b1);
        check("bp_b2b_valid", 32'(rsp_valid), 32'd1);
        check("bp_b2b_id", 32'(rsp_id), 32'd1);

        // Illegal op: zero data, error flag, pointer still advances.
        req_valid = 2'b01;
        set_req(0, 4'b1010, 32'd3, 32'd3);
        step(1'b1);
        check("illegal_err", 32'(rsp_err), 32'd1);
        check("illegal_data", rsp_data, 32'd0);
        req_valid = 2'b11;
        step(1'b1);
        check("illegal_next_id", 32'(rsp_id), 32'd1);

        // Randomized traffic honouring the hold-while-not-ready rule.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc[i])) begin
                    logic [31:0] a, b;
                    a = $urandom;
                    b = $urandom;
                    if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
                    if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    set_req(i, 4'($urandom_range(0, 15)), a, b);
                end
            end
            step($urandom_range(0, 3) != 0);
        end

        // Reset while a result is held under back-pressure.
        req_valid = 2'b00;
        step(1'b1);
        req_valid = 2'b10;
        set_req(1, 4'b0111, 32'hF0F0_F0F0, 32'hFFFF_0000);
        step(1'b0);
        check("pre_reset_valid", 32'(rsp_valid), 32'd1);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset_data", rsp_data, 32'd0);
        check("mid_reset_ready", 32'(req_ready), 32'd0);
        model_reset();
        req_valid = 2'b00;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b11;
        set_req(0, 4'b0000, 32'd1, 32'd1);
        set_req(1, 4'b0000, 32'd2, 32'd2);
        step(1'b1);
        check("post_reset_id", 32'(rsp_id), 32'd0);
        check("post_reset_data", rsp_data, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/r_alu_arbiter.md
# r_alu_arbiter

Round-robin arbiter that shares one R-type ALU datapath between `NUM_REQ` issue ports. Each requester presents a valid/ready request carrying the instruction word and two operands. The arbiter grants one request per cycle, computes the result, and registers it into a single response slot tagged with the requester index. It sits between the decode/issue stage and the writeback stage, and is the only path into the shared ALU.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..4).
- `XLEN`, default 32: operand/result width (fixed at 32 for RV32).
- `ID_W`, default `$clog2(NUM_REQ)`: requester-index width. Derived; do not override.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `req_instr`  in  NUM_REQ×32  instruction word; bits [30] and [14:12] are used.
- `req_in1`, `req_in2`  in  NUM_REQ×XLEN  operands rs1 and rs2.
- `rsp_valid`  out  1  result slot occupied.
- `rsp_ready`  in  1  writeback accepts the result.
- `rsp_data`  out  XLEN  ALU result.
- `rsp_id`  out  ID_W  index of the requester that produced `rsp_data`.
- `rsp_err`  out  1  illegal {instr[30], funct3} encoding.

## Operation
- Op code is `{instr[30], instr[14:12]}`. The legal codes are:
  - 0000 add, 1000 sub, 0001 sll, 0010 slt (signed), 0011 sltu
  - 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and
- Any other code (1001, 1010, 1011, 1100, 1110, 1111) is illegal. It is still accepted, and produces `rsp_data`=0 with `rsp_err`=1.
- Shift amount is `in2[4:0]`. slt/sltu return 0 or 1, zero-extended. add/sub wrap modulo 2^32.
- Slot free condition: `free = !rsp_valid || rsp_ready`.
- Grant: the first requester with `req_valid` high, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - `req_ready[g]` = `free` for the granted index only. All other bits are 0.
  - `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`.
- Accept happens when `req_valid[g] && req_ready[g]`. On accept:
  - The ALU result, g and the error flag are registered into the slot, and `rsp_valid` is set.
  - `rr_ptr` becomes (g+1) mod NUM_REQ.
- Without an accept, `rr_ptr` holds.
- If `rsp_ready` is high, `rsp_valid` is high and there is no accept, `rsp_valid` clears.
- While `rsp_valid && !rsp_ready`:
  - `rsp_data`, `rsp_id` and `rsp_err` hold stable.
  - `req_ready` is all 0 (back-pressure).
- Requesters must hold their request stable while valid and not ready. The arbiter does not check this.
- Slot state machine:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with `rsp_ready` (back-to-back).
  - FULL → EMPTY on `rsp_ready` with no accept.
  - FULL holds without `rsp_ready`.

## Timing
- Latency: request accepted at edge N, result visible on `rsp_*` immediately after edge N.
- Throughput: one result per cycle when `rsp_ready` is held high.
- No combinational path from `req_*` to `rsp_*`. All `rsp_*` outputs come from flops.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `rr_ptr`=0.
  - `req_ready` is 0 while `rst_n` is low.
- Reset mid-operation: a held result is discarded and its requester is not re-notified.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one with no bubble.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.

## Structure
- Package `r_alu_pkg` holds:
  - `alu_op_e`, a 4-bit enum with the ten legal codes above.
  - Function `is_legal_op(logic [3:0])`.
  - Localparam `XLEN = 32`.
- Sub-module `r_alu_core` is a purely combinational ALU:
  - Inputs: `op`, `in1`, `in2`.
  - Outputs: `out`, `illegal`.
  - Uses `unique case` with a default branch that drives 0 and `illegal`.
- The top level holds the round-robin grant logic, the operand mux feeding `r_alu_core`, the slot register and `rr_ptr`.

## Test plan
- Single add: req0 with code 0000, in1=5, in2=7, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_data`=12, `rsp_id`=0, `rsp_err`=0.
- Op sweep on req1 with in1=0x8000_0000, in2=0x0000_0004:
  - sub → 0x7FFF_FFFC
  - sra → 0xF800_0000
  - srl → 0x0800_0000
  - slt → 1
  - sltu → 0
  - sll → 0
- Contention: both requesters valid for 6 cycles, `rsp_ready`=1 → `rsp_id` sequence 0,1,0,1,0,1.
- Back-pressure: `rsp_ready`=0 for 3 cycles while a result is held → `req_ready`=0 and `rsp_*` stable. Raising `rsp_ready` with a new request pending gives a back-to-back accept with no empty cycle.
- Illegal op: code 1010 with in1=in2=3 → `rsp_err`=1, `rsp_data`=0, `rr_ptr` advances.
- Reset mid-stream: assert `rst_n`=0 while `rsp_valid`=1 and `rsp_ready`=0 → `rsp_valid` drops asynchronously. After release, the first grant goes to req0 when both requesters are valid.
